multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters; all encodings SHALL come from the shared package.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; zero  in  1  ALU zero flag.
REQ-005 mem_ready  in  1  memory handshake; access completes in the cycle it is high.
REQ-006 pc_en  out  1  PC load enable.
REQ-007 i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a, zero_ext  out  1 each  datapath enables and selects.
REQ-008 reg_dst  out  2  write-register select: 00 rt, 01 rd, 10 $ra.
REQ-009 mem_to_reg  out  2  write-data select: 00 ALUOut, 01 MDR, 10 PC.
REQ-010 alu_src_b  out  2  ALU B select: 00 rt data, 01 constant 4, 10 extended immediate, 11 sign-extended immediate<<2.
REQ-011 pc_source  out  2  PC select: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs data.
REQ-012 alu_op  out  4  ALUOp codes: R 1111, add 1000, ori 1010, andi 1100, lui 0010, beq 0100, bne 0111, sw 0110, lw 1110.
REQ-013 instr_done, illegal_op  out  1 each  one-cycle retire and illegal-opcode pulses.

Function
REQ-014 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR.
REQ-015 Outputs not listed for a state SHALL be 0.
REQ-016 FETCH SHALL assert mem_read, with i_or_d=0, alu_src_b=01 and alu_op=1000.
REQ-017 FETCH SHALL hold while mem_ready=0; when mem_ready=1 it SHALL pulse ir_write and pc_en in that cycle and go to DECODE.
REQ-018 DECODE SHALL drive alu_src_b=11 and alu_op=1000 to compute the branch target.
REQ-019 DECODE SHALL dispatch as follows:
- R-type (000000) with funct 001000 -> JR; other R-type -> R_EXEC.
- lw (100011), sw (101011) -> MEM_ADDR.
- addi (001000), andi (001100), ori (001101), lui (001111) -> I_EXEC.
- beq (000100), bne (000101) -> BRANCH.
- j (000010) -> JUMP; jal (000011) -> JAL.
REQ-020 An unlisted opcode in DECODE SHALL pulse illegal_op and return to FETCH with no state written.
REQ-021 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=1111, then go to R_WB.
REQ-022 R_WB SHALL drive reg_dst=01, mem_to_reg=00 and reg_write, then go to FETCH.
REQ-023 I_EXEC SHALL drive alu_src_a=1, alu_src_b=10 and the opcode's alu_op, with zero_ext=1 for andi/ori only, then go to I_WB.
REQ-024 I_WB SHALL drive reg_dst=00, mem_to_reg=00 and reg_write, then go to FETCH.
REQ-025 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op 1110 for lw or 0110 for sw, then go to MEM_READ (lw) or MEM_WRITE (sw).
REQ-026 MEM_READ SHALL drive i_or_d=1 and mem_read, holding until mem_ready=1, then go to MEM_WB.
REQ-027 MEM_WB SHALL drive reg_dst=00, mem_to_reg=01 and reg_write, then go to FETCH.
REQ-028 MEM_WRITE SHALL drive i_or_d=1 and mem_write, holding until mem_ready=1, then go to FETCH.
REQ-029 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op 0100/0111 and pc_source=01.
REQ-030 In BRANCH, pc_en SHALL be combinational: zero for beq, !zero for bne; the next state SHALL be FETCH.
REQ-031 JUMP SHALL drive pc_source=10 and pc_en.
REQ-032 JAL SHALL additionally drive reg_write, reg_dst=10 and mem_to_reg=10 (PC already holds PC+4).
REQ-033 JR SHALL drive pc_source=11 and pc_en.
REQ-034 JUMP, JAL and JR SHALL each go to FETCH after one cycle.
REQ-035 instr_done SHALL pulse in the final cycle of every legal instruction: R_WB, I_WB, MEM_WB, the MEM_WRITE cycle with mem_ready=1, BRANCH, JUMP, JAL, JR.
REQ-036 Latency, with zero memory wait: branch/jump 3 cycles, R/I 4, sw 4, lw 5; each mem_ready=0 cycle adds one.

Reset
REQ-037 While reset=0 at a rising edge, the state SHALL become FETCH, including mid-instruction or mid-wait.
REQ-038 While reset=0, every output SHALL be 0, except alu_op=1000 and alu_src_b=01.
REQ-039 The first fetch SHALL begin in the first cycle after reset=1.

Structure
REQ-040 The package mips_ctrl_pkg SHALL hold the state enum, opcode/funct constants, ALUOp codes and mux-select encodings.
REQ-041 The opcode->alu_op mapping SHALL be the combinational sub-module aluop_decode.
REQ-042 The block SHALL use one state register with a next-state/output decode; no other storage.

Verification
REQ-043 add (opcode 000000, funct 100000), mem_ready=1 -> FETCH,DECODE,R_EXEC,R_WB; reg_write=1 with reg_dst=01 in cycle 4; instr_done in cycle 4.
REQ-044 lw with mem_ready low 2 cycles in MEM_READ -> MEM_READ held 3 cycles; MEM_WB has mem_to_reg=01; total 7 cycles.
REQ-045 beq with zero=0 -> pc_en=0 in BRANCH; bne with zero=0 -> pc_en=1, pc_source=01.
REQ-046 jal -> JAL cycle has pc_en=1, reg_dst=10, mem_to_reg=10, reg_write=1; then FETCH.
REQ-047 opcode 111111 -> illegal_op pulse in DECODE, no reg_write/mem_write, FETCH next.
REQ-048 reset=0 asserted during MEM_WRITE wait -> mem_write=0 that cycle, FETCH after reset release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// ALUOp codes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [3:0] ALU_R    = 4'b1111;
    localparam logic [3:0] ALU_ADD  = 4'b1000;
    localparam logic [3:0] ALU_ORI  = 4'b1010;
    localparam logic [3:0] ALU_ANDI = 4'b1100;
    localparam logic [3:0] ALU_LUI  = 4'b0010;
    localparam logic [3:0] ALU_BEQ  = 4'b0100;
    localparam logic [3:0] ALU_BNE  = 4'b0111;
    localparam logic [3:0] ALU_SW   = 4'b0110;
    localparam logic [3:0] ALU_LW   = 4'b1110;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

endpackage

// File: rtl/multicycle_control_aluop_decode.sv
// Opcode to ALUOp mapping used by the execute/address/branch states.
module aluop_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: alu_op = ALU_R;
            OP_ADDI:  alu_op = ALU_ADD;
            OP_ORI:   alu_op = ALU_ORI;
            OP_ANDI:  alu_op = ALU_ANDI;
            OP_LUI:   alu_op = ALU_LUI;
            OP_BEQ:   alu_op = ALU_BEQ;
            OP_BNE:   alu_op = ALU_BNE;
            OP_SW:    alu_op = ALU_SW;
            OP_LW:    alu_op = ALU_LW;
            default:  alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM. States: FETCH/DECODE (common), MEM_ADDR..MEM_WRITE (lw/sw),
// R_EXEC/R_WB, I_EXEC/I_WB, BRANCH (beq/bne), JUMP/JAL/JR (one-cycle PC updates).
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       zero_ext,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_op,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state, next_state;
    logic [3:0] dec_alu_op;

    aluop_decode u_aluop_decode (
        .opcode (opcode),
        .alu_op (dec_alu_op)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        zero_ext   = 1'b0;
        reg_dst    = REGDST_RT;
        mem_to_reg = WB_ALUOUT;
        alu_src_b  = SRCB_REG;
        pc_source  = PCSRC_ALU;
        alu_op     = 4'b0000;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        // Reset overrides the current state so no strobe escapes mid-instruction.
        if (!reset) begin
            next_state = S_FETCH;
            alu_src_b  = SRCB_FOUR;
            alu_op     = ALU_ADD;
        end else begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALU_ADD;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_en      = 1'b1;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRCB_BROFF;
                    alu_op    = ALU_ADD;
                    case (opcode)
                        OP_RTYPE: next_state = (funct == FN_JR) ? S_JR : S_R_EXEC;
                        OP_LW, OP_SW: next_state = S_MEM_ADDR;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: next_state = S_I_EXEC;
                        OP_BEQ, OP_BNE: next_state = S_BRANCH;
                        OP_J:     next_state = S_JUMP;
                        OP_JAL:   next_state = S_JAL;
                        default: begin
                            illegal_op = 1'b1;
                            next_state = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    alu_op     = dec_alu_op;
                    next_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) next_state = S_MEM_WB;
                end
                S_MEM_WB: begin
                    reg_dst    = REGDST_RT;
                    mem_to_reg = WB_MDR;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEM_WRITE: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        next_state = S_FETCH;
                    end
                end
                S_R_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_REG;
                    alu_op     = ALU_R;
                    next_state = S_R_WB;
                end
                S_R_WB: begin
                    reg_dst    = REGDST_RD;
                    mem_to_reg = WB_ALUOUT;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_I_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    alu_op     = dec_alu_op;
                    zero_ext   = (opcode == OP_ANDI) || (opcode == OP_ORI);
                    next_state = S_I_WB;
                end
                S_I_WB: begin
                    reg_dst    = REGDST_RT;
                    mem_to_reg = WB_ALUOUT;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_REG;
                    alu_op     = dec_alu_op;
                    pc_source  = PCSRC_ALUOUT;
                    pc_en      = (opcode == OP_BNE) ? !zero : zero;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_JUMP: begin
                    pc_source  = PCSRC_JUMP;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_JAL: begin
                    pc_source  = PCSRC_JUMP;
                    pc_en      = 1'b1;
                    reg_write  = 1'b1;
                    reg_dst    = REGDST_RA;
                    mem_to_reg = WB_PC;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_JR: begin
                    pc_source  = PCSRC_RS;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

endmodule
